// File: rtl/dac_update_sched.sv
// Round-robin scheduler sharing one write-only SPI master among N_CH DAC requesters.
// Optional build macro DAC_SCHED_SKIP_DUP_EN suppresses frames identical to the last one sent on a channel.
module dac_update_sched #(
    parameter int N_CH    = 4,
    parameter int CODE_W  = 8,
    parameter int FRAME_W = 16,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic [N_CH-1:0]        req_i,
    input  logic [N_CH*CODE_W-1:0] code_i,
    input  logic [N_CH*2-1:0]      pd_i,
    output logic [N_CH-1:0]        busy_o,
    output logic [N_CH-1:0]        done_o,
    output logic [FRAME_W-1:0]     spi_data_o,
    output logic                   spi_wre_o,
    input  logic                   spi_rdy_i,
    output logic [SEL_W-1:0]       cs_sel_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_HI} state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_ptr;
    logic [SEL_W-1:0]    r_sel;
    logic [N_CH-1:0]     r_pend;
    logic [N_CH-1:0]     r_flight;
    logic [N_CH-1:0]     r_done;
    logic [FRAME_W-1:0]  r_data;
    logic                r_wre;
    logic [CODE_W-1:0]   r_code [N_CH];
    logic [1:0]          r_pd   [N_CH];

    logic                w_any;
    logic [SEL_W-1:0]    w_gnt;
    logic [SEL_W-1:0]    w_ptr_nxt;
    logic                w_grant_en;
    logic [N_CH-1:0]     w_gnt_oh;
    logic [FRAME_W-1:0]  w_frame;
    logic                w_skip;

    // NOTE: request slots carry no reset; pend gates every read, so stale contents are never used.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < N_CH; k++) begin
            if (req_i[k]) begin
                r_code[k] <= code_i[k*CODE_W +: CODE_W];
                r_pd[k]   <= pd_i[k*2 +: 2];
            end
        end
    end

    // Scan from the highest offset down so the lowest offset from r_ptr is the last to win.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            int idx;
            idx = int'(r_ptr) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (r_pend[idx]) begin
                w_any = 1'b1;
                w_gnt = SEL_W'(idx);
            end
        end
    end

    assign w_ptr_nxt  = (w_gnt == SEL_W'(N_CH - 1)) ? '0 : w_gnt + 1'b1;
    assign w_grant_en = (r_state == S_IDLE) && w_any && spi_rdy_i;
    assign w_gnt_oh   = N_CH'(1) << w_gnt;
    assign w_frame    = FRAME_W'({2'b00, r_pd[w_gnt], r_code[w_gnt], 4'b0000});

`ifdef DAC_SCHED_SKIP_DUP_EN
    logic [CODE_W-1:0] r_last_code [N_CH];
    logic [1:0]        r_last_pd   [N_CH];
    logic [N_CH-1:0]   r_last_vld;

    assign w_skip = r_last_vld[w_gnt] && (r_last_code[w_gnt] == r_code[w_gnt])
                    && (r_last_pd[w_gnt] == r_pd[w_gnt]);

    // last_sent follows the frame actually on the wire, captured when it completes.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_last_vld <= '0;
            for (int k = 0; k < N_CH; k++) begin
                r_last_code[k] <= '0;
                r_last_pd[k]   <= '0;
            end
        end else if (r_state == S_WAIT_HI && spi_rdy_i) begin
            r_last_vld[r_sel]  <= 1'b1;
            r_last_code[r_sel] <= r_data[4 +: CODE_W];
            r_last_pd[r_sel]   <= r_data[4 + CODE_W +: 2];
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    // NOTE: all state here is non-blocking so every branch sees pre-edge values.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_sel    <= '0;
            r_pend   <= '0;
            r_flight <= '0;
            r_done   <= '0;
            r_data   <= '0;
            r_wre    <= 1'b0;
        end else begin
            // A fresh request beats the grant clear so the new slot contents are sent later.
            r_pend <= (r_pend & ~(w_grant_en ? w_gnt_oh : '0)) | req_i;
            r_wre  <= 1'b0;
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_en) begin
                        r_ptr <= w_ptr_nxt;
                        if (w_skip) begin
                            r_done <= w_gnt_oh;
                        end else begin
                            r_sel    <= w_gnt;
                            r_data   <= w_frame;
                            r_flight <= w_gnt_oh;
                            r_wre    <= 1'b1;
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE:   r_state <= S_WAIT_LO;
                S_WAIT_LO: if (!spi_rdy_i) r_state <= S_WAIT_HI;
                S_WAIT_HI: begin
                    if (spi_rdy_i) begin
                        r_done   <= N_CH'(1) << r_sel;
                        r_flight <= '0;
                        r_state  <= S_IDLE;
                    end
                end
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = r_pend | r_flight;
    assign done_o     = r_done;
    assign spi_data_o = r_data;
    assign spi_wre_o  = r_wre;
    assign cs_sel_o   = r_sel;

endmodule

// File: tb/tb_dac_update_sched.sv
// Scoreboard bench for dac_update_sched with a behavioural SPI master (rdy drops after each wre).
// Build with DAC_SCHED_SKIP_DUP_EN to exercise the duplicate-skip variant.
module tb_dac_update_sched;

    localparam int N_CH    = 4;
    localparam int CODE_W  = 8;
    localparam int FRAME_W = 16;
    localparam int SEL_W   = 2;
    localparam int SPI_LEN = 6;

    logic                   clk_i;
    logic                   arst_i;
    logic [N_CH-1:0]        req_i;
    logic [N_CH*CODE_W-1:0] code_i;
    logic [N_CH*2-1:0]      pd_i;
    logic [N_CH-1:0]        busy_o;
    logic [N_CH-1:0]        done_o;
    logic [FRAME_W-1:0]     spi_data_o;
    logic                   spi_wre_o;
    logic                   spi_rdy_i;
    logic [SEL_W-1:0]       cs_sel_o;

    dac_update_sched #(.N_CH(N_CH), .CODE_W(CODE_W), .FRAME_W(FRAME_W)) dut (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .req_i      (req_i),
        .code_i     (code_i),
        .pd_i       (pd_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .spi_data_o (spi_data_o),
        .spi_wre_o  (spi_wre_o),
        .spi_rdy_i  (spi_rdy_i),
        .cs_sel_o   (cs_sel_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Behavioural SPI master: rdy low for SPI_LEN clocks after each write strobe.
    int spi_cnt;
    always @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            spi_rdy_i <= 1'b1;
            spi_cnt   <= 0;
        end else if (spi_wre_o) begin
            spi_rdy_i <= 1'b0;
            spi_cnt   <= SPI_LEN;
        end else if (spi_cnt != 0) begin
            spi_cnt <= spi_cnt - 1;
            if (spi_cnt == 1) spi_rdy_i <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_wre    = 0;
    logic [SEL_W+FRAME_W-1:0] exp_frame_q[$];
    int                       exp_done_q[$];
    logic [SEL_W+FRAME_W-1:0] mon_frame;
    int                       mon_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [FRAME_W-1:0] frm(input logic [7:0] code, input logic [1:0] pd);
        return {2'b00, pd, code, 4'b0000};
    endfunction

    always @(negedge clk_i) begin
        if (!arst_i && spi_wre_o) begin
            n_wre++;
            if (exp_frame_q.size() == 0) begin
                check("unexpected_wre", 32'(spi_data_o), 32'hFFFF_FFFF);
            end else begin
                mon_frame = exp_frame_q.pop_front();
                check("frame_data", 32'(spi_data_o), 32'(mon_frame[FRAME_W-1:0]));
                check("frame_sel", 32'(cs_sel_o), 32'(mon_frame[SEL_W+FRAME_W-1:FRAME_W]));
            end
        end
    end

    always @(negedge clk_i) begin
        if (!arst_i && done_o != '0) begin
            if (exp_done_q.size() == 0) begin
                check("unexpected_done", 32'(done_o), 32'h0);
            end else begin
                mon_done = exp_done_q.pop_front();
                check("done_ch", 32'(done_o), 32'(1) << mon_done);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] code, input logic [1:0] pd);
        req_i[ch]              = 1'b1;
        code_i[ch*CODE_W +: 8] = code;
        pd_i[ch*2 +: 2]        = pd;
    endtask

    task automatic pulse();
        tick();
        req_i = '0;
    endtask

    task automatic expect_frame(input int ch, input logic [FRAME_W-1:0] data);
        exp_frame_q.push_back({SEL_W'(ch), data});
        exp_done_q.push_back(ch);
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((busy_o != '0 || exp_frame_q.size() != 0 || exp_done_q.size() != 0) && i < 300) begin
            tick();
            i++;
        end
        check(name, 32'(i < 300), 32'h1);
    endtask

    task automatic wait_wre(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_i);
            seen = spi_wre_o;
        end
        check(name, 32'(seen), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int seen;
        bit held;
        arst_i = 1'b1;
        req_i  = '0;
        code_i = '0;
        pd_i   = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        check("rst_wre", 32'(spi_wre_o), 32'h0);
        check("rst_data", 32'(spi_data_o), 32'h0);
        check("rst_sel", 32'(cs_sel_o), 32'h0);
        arst_i = 1'b0;
        tick();

        // All four channels at once from ptr=0: served 0,1,2,3.
        set_ch(0, 8'h12, 2'b01);
        set_ch(1, 8'h34, 2'b10);
        set_ch(2, 8'h56, 2'b11);
        set_ch(3, 8'h78, 2'b00);
        expect_frame(0, 16'h1120);
        expect_frame(1, 16'h2340);
        expect_frame(2, 16'h3560);
        expect_frame(3, 16'h0780);
        base = n_wre;
        pulse();
        check("t2_busy", 32'(busy_o), 32'hF);
        drain("t2_drain");
        check("t2_wre_cnt", 32'(n_wre - base), 32'd4);

        // Single request on ch2, 2-clk req->wre latency.
        set_ch(2, 8'hA5, 2'b00);
        expect_frame(2, 16'h0A50);
        base = n_wre;
        pulse();
        check("t1_busy", 32'(busy_o), 32'h4);
        @(negedge clk_i);
        check("t1_wre_early", 32'(spi_wre_o), 32'h0);
        @(negedge clk_i);
        check("t1_wre_lat", 32'(spi_wre_o), 32'h1);
        @(negedge clk_i);
        check("t1_wre_one_clk", 32'(spi_wre_o), 32'h0);
        check("t1_data_held", 32'(spi_data_o), 32'h0A50);
        check("t1_busy_hold", 32'(busy_o), 32'h4);
        tick();
        drain("t1_drain");
        check("t1_busy_end", 32'(busy_o), 32'h0);
        check("t1_wre_cnt", 32'(n_wre - base), 32'd1);

        // Latest wins on ch1 while ch0 is in flight.
        set_ch(0, 8'h01, 2'b10);
        expect_frame(0, 16'h2010);
        base = n_wre;
        pulse();
        wait_wre("t3_wre0");
        tick();
        set_ch(1, 8'h10, 2'b00);
        pulse();
        set_ch(1, 8'h20, 2'b00);
        expect_frame(1, 16'h0200);
        pulse();
        drain("t3_drain");
        check("t3_wre_cnt", 32'(n_wre - base), 32'd2);

        // Re-request ch3 while its frame is in WAIT_HI.
        set_ch(3, 8'h11, 2'b01);
        expect_frame(3, 16'h1110);
        pulse();
        wait_wre("t4_wre0");
        repeat (3) tick();
        set_ch(3, 8'h33, 2'b00);
        expect_frame(3, 16'h0330);
        pulse();
        seen = 0;
        held = 1'b1;
        for (int i = 0; i < 200 && seen < 2; i++) begin
            @(negedge clk_i);
            if (done_o[3]) seen++;
            if (seen < 2 && !busy_o[3]) held = 1'b0;
        end
        check("t4_busy_held", 32'(held), 32'h1);
        check("t4_done_cnt", 32'(seen), 32'd2);
        tick();
        drain("t4_drain");

        // Reset during WAIT_LO clears everything and suppresses done.
        set_ch(1, 8'hC3, 2'b11);
        expect_frame(1, 16'h3C30);
        pulse();
        wait_wre("t5_wre");
        tick();
        arst_i = 1'b1;
        #1;
        check("t5_busy", 32'(busy_o), 32'h0);
        check("t5_data", 32'(spi_data_o), 32'h0);
        check("t5_sel", 32'(cs_sel_o), 32'h0);
        check("t5_wre", 32'(spi_wre_o), 32'h0);
        check("t5_done", 32'(done_o), 32'h0);
        exp_done_q.delete();
        repeat (2) tick();
        arst_i = 1'b0;
        repeat (20) tick();
        check("t5_quiet", 32'(busy_o), 32'h0);
        check("t5_frames_left", 32'(exp_frame_q.size()), 32'h0);

        // Repeat of an identical code on ch0, then a changed code.
        set_ch(0, 8'h40, 2'b00);
        expect_frame(0, 16'h0400);
        pulse();
        drain("t6_first");
        set_ch(0, 8'h40, 2'b00);
        base = n_wre;
`ifdef DAC_SCHED_SKIP_DUP_EN
        exp_done_q.push_back(0);
        pulse();
        @(posedge clk_i);
        @(negedge clk_i);
        check("t6_skip_done", 32'(done_o), 32'h1);
        check("t6_skip_wre", 32'(spi_wre_o), 32'h0);
        tick();
        drain("t6_dup_drain");
        check("t6_dup_wre_cnt", 32'(n_wre - base), 32'd0);
`else
        expect_frame(0, 16'h0400);
        pulse();
        drain("t6_dup_drain");
        check("t6_dup_wre_cnt", 32'(n_wre - base), 32'd1);
`endif
        set_ch(0, 8'h41, 2'b00);
        expect_frame(0, 16'h0410);
        base = n_wre;
        pulse();
        drain("t6_new_drain");
        check("t6_new_wre_cnt", 32'(n_wre - base), 32'd1);

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
